// File: rtl/ifu_prefetch_buf.sv
// ifu_prefetch_buf: sequential fetch unit with a DEPTH-entry prefetch FIFO.
// Ports: clk/rst_n, en, redirect_valid/redirect_pc, out_* (IDU handshake),
//   busy, pmem_rd_en/pmem_rd_addr/pmem_rd_data (the npc_pmem_read call).
// pmem_rd_en pulses for exactly one cycle per completed fetch; the read
//   is combinational and its data is sampled on the completion edge.
// Macro IFU_MISALIGN_CHECK_EN: misaligned req_pc pushes a fault entry
//   instead of reading pmem and halts issue until the next redirect.
module ifu_prefetch_buf #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 4,
  parameter int          LATENCY  = 1,
  parameter int          CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault,
  output logic        busy,
  output logic        pmem_rd_en,
  output logic [31:0] pmem_rd_addr,
  input  logic [63:0] pmem_rd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);
  localparam logic [CW-1:0]    FULL   = CW'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_req_pc;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             r_halt;

  logic [31:0]      r_pc_q    [DEPTH];
  logic [31:0]      r_inst_q  [DEPTH];
  logic             r_fault_q [DEPTH];

  logic             w_done;
  logic             w_misalign;
  logic             w_push;
  logic             w_pop;
  logic             w_issue;
  logic             w_room;
  logic [CW-1:0]    w_count_nxt;
  logic [31:0]      w_inst;
  logic             w_fault;
  logic [31:0]      w_pc_inc;

  assign w_done = (r_state == S_WAIT) && (r_cnt == '0);

`ifdef IFU_MISALIGN_CHECK_EN
  assign w_misalign = (r_req_pc[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_push = w_done;
  assign w_pop  = out_valid && out_ready;

  assign w_count_nxt = r_count
                     + CW'(w_push)
                     - CW'(w_pop);

  assign w_room  = w_count_nxt < FULL;
  assign w_issue = en && (r_count < FULL) && !r_halt;

  assign w_pc_inc = r_req_pc + 32'd4;

  // A redirect in the completion cycle aborts the read entirely.
  assign pmem_rd_en   = w_done && !redirect_valid && !w_misalign;
  assign pmem_rd_addr = r_req_pc;

  always_comb begin
    w_inst  = r_req_pc[2] ? pmem_rd_data[63:32]
                          : pmem_rd_data[31:0];
    w_fault = 1'b0;
    if (w_misalign) begin
      w_inst  = 32'h0;
      w_fault = 1'b1;
    end
  end

  assign out_valid = (r_count != '0);
  assign out_pc    = out_valid ? r_pc_q[r_rd_ptr]    : 32'h0;
  assign out_inst  = out_valid ? r_inst_q[r_rd_ptr]  : 32'h0;
  assign out_fault = out_valid ? r_fault_q[r_rd_ptr] : 1'b0;
  assign busy      = (r_state == S_WAIT);

  // FIFO storage carries no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push && !redirect_valid) begin
      r_pc_q[r_wr_ptr]    <= r_req_pc;
      r_inst_q[r_wr_ptr]  <= w_inst;
      r_fault_q[r_wr_ptr] <= w_fault;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= 32'h0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_halt     <= 1'b0;
    end else if (redirect_valid) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_fetch_pc <= redirect_pc;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_halt     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state  <= S_WAIT;
            r_req_pc <= r_fetch_pc;
            r_cnt    <= LAT_M1;
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_fetch_pc <= w_pc_inc;
            if (w_misalign) begin
              r_halt  <= 1'b1;
              r_state <= S_IDLE;
            end else if (en && w_room) begin
              // back-to-back reissue keeps 1 inst/cycle at LATENCY=1
              r_req_pc <= w_pc_inc;
              r_cnt    <= LAT_M1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_prefetch_buf.sv
// tb_ifu_prefetch_buf: directed bench for ifu_prefetch_buf.
// Two instances: LATENCY=1 (main) and LATENCY=3 (pacing checks).
module tb_ifu_prefetch_buf;

  localparam logic [31:0] K = 32'h1234_5678;

  logic        clk;
  logic        rst_n;

  logic        en, rdv, rdy;
  logic [31:0] rdpc;
  logic        ov, of, bsy, rd_en;
  logic [31:0] opc, oinst, rd_addr;
  logic [63:0] rd_data;

  logic        en3, rdy3;
  logic        ov3, of3, bsy3, rd_en3;
  logic [31:0] opc3, oinst3, rd_addr3;
  logic [63:0] rd_data3;
  logic        rdv3;
  logic [31:0] rdpc3;

  int n_chk;
  int n_fail;
  int cyc;
  int n_calls;
  logic [31:0] last_addr;
  int n3;
  int c3_last, c3_prev;
  int base;

  function automatic logic [63:0] pmem(input logic [31:0] a);
    if (a[31:3] == 29'h1000_0000)
      return 64'h00100093_00000413;
    return {{a[31:3], 3'b100} ^ K, {a[31:3], 3'b000} ^ K};
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    if (pc == 32'h8000_0000) return 32'h0000_0413;
    if (pc == 32'h8000_0004) return 32'h0010_0093;
    return pc ^ K;
  endfunction

  assign rd_data  = pmem(rd_addr);
  assign rd_data3 = pmem(rd_addr3);

  ifu_prefetch_buf #(.LATENCY(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .redirect_valid(rdv), .redirect_pc(rdpc),
    .out_valid(ov), .out_ready(rdy),
    .out_pc(opc), .out_inst(oinst), .out_fault(of),
    .busy(bsy), .pmem_rd_en(rd_en),
    .pmem_rd_addr(rd_addr), .pmem_rd_data(rd_data)
  );

  ifu_prefetch_buf #(.LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3),
    .redirect_valid(rdv3), .redirect_pc(rdpc3),
    .out_valid(ov3), .out_ready(rdy3),
    .out_pc(opc3), .out_inst(oinst3), .out_fault(of3),
    .busy(bsy3), .pmem_rd_en(rd_en3),
    .pmem_rd_addr(rd_addr3), .pmem_rd_data(rd_data3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0; n_calls = 0; last_addr = '0;
    n3 = 0; c3_last = 0; c3_prev = 0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && rd_en) begin
      n_calls   <= n_calls + 1;
      last_addr <= rd_addr;
    end
    if (rst_n && rd_en3) begin
      n3      <= n3 + 1;
      c3_prev <= c3_last;
      c3_last <= cyc;
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    en = 0; rdv = 0; rdpc = '0; rdy = 1;
    en3 = 0; rdy3 = 1; rdv3 = 0; rdpc3 = '0;
    tick(2);

    // reset state
    check("rst_valid", ov, 0);
    check("rst_pc", opc, 0);
    check("rst_inst", oinst, 0);
    check("rst_fault", of, 0);
    check("rst_busy", bsy, 0);
    check("rst_calls", n_calls, 0);
    check("rst_valid3", ov3, 0);

    // LATENCY=3 pacing, main instance idle
    rst_n = 1'b1;
    en3 = 1;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      check($sformatf("l3_busy_%0d", k), bsy3, 1);
      check($sformatf("l3_valid_%0d", k), ov3,
            (k >= 4 && (k % 3) == 1) ? 1 : 0);
      if (k == 4) check("l3_pc0", opc3, 32'h8000_0000);
      if (k == 7) begin
        check("l3_pc1", opc3, 32'h8000_0004);
        check("l3_ncalls", n3, 2);
        check("l3_spacing", c3_last - c3_prev, 3);
      end
    end
    // en drop mid-fetch: in-flight fetch still lands
    en3 = 0;
    tick(1);
    check("l3_en_push", ov3, 1);
    check("l3_en_pc", opc3, 32'h8000_0008);
    check("l3_en_busy", bsy3, 0);
    tick(1);
    check("l3_en_empty", ov3, 0);
    check("l3_en_calls", n3, 3);

    // basic streaming at LATENCY=1
    rst_n = 1'b0;
    tick(2);
    base = n_calls;
    rst_n = 1'b1;
    en = 1; rdy = 1;
    tick(1);
    check("t1_valid_e1", ov, 0);
    check("t1_busy_e1", bsy, 1);
    tick(1);
    check("t1_pc0", opc, 32'h8000_0000);
    check("t1_inst0", oinst, 32'h0000_0413);
    tick(1);
    check("t1_pc1", opc, 32'h8000_0004);
    check("t1_inst1", oinst, 32'h0010_0093);
    tick(1);
    check("t1_pc2", opc, 32'h8000_0008);
    check("t1_inst2", oinst, exp_inst(32'h8000_0008));

    // fill with ready low, then push+pop at DEPTH-1
    rst_n = 1'b0;
    tick(2);
    base = n_calls;
    rst_n = 1'b1;
    en = 1; rdy = 0;
    tick(7);
    check("t2_calls", n_calls - base, 4);
    check("t2_busy", bsy, 0);
    check("t2_head", opc, 32'h8000_0000);
    check("t2_valid", ov, 1);
    rdy = 1;
    tick(1);
    check("t6_head1", opc, 32'h8000_0004);
    check("t6_busy0", bsy, 0);
    rdy = 0;
    tick(1);
    check("t6_issue", bsy, 1);
    check("t6_hold", opc, 32'h8000_0004);
    rdy = 1;
    tick(1);
    check("t6_reissue", bsy, 1);
    check("t6_head2", opc, 32'h8000_0008);
    check("t6_calls5", n_calls - base, 5);
    rdy = 0;
    tick(1);
    check("t6_full_busy", bsy, 0);
    check("t6_calls6", n_calls - base, 6);
    check("t6_head_st", opc, 32'h8000_0008);
    rdy = 1;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check($sformatf("t2_drain_pc%0d", k), opc,
            32'h8000_000C + 32'(4 * k));
      check($sformatf("t2_drain_in%0d", k), oinst,
            exp_inst(32'h8000_000C + 32'(4 * k)));
    end

    // redirect with 3 entries and a fetch in flight
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    en = 1; rdy = 0;
    tick(4);
    check("t4_pre_busy", bsy, 1);
    check("t4_pre_head", opc, 32'h8000_0000);
    base = n_calls;
    rdv = 1; rdpc = 32'h8000_0100;
    tick(1);
    rdv = 0; rdy = 1;
    check("t4_flush", ov, 0);
    check("t4_abort_calls", n_calls - base, 0);
    tick(1);
    check("t4_reissue", bsy, 1);
    check("t4_empty", ov, 0);
    tick(1);
    check("t4_pc", opc, 32'h8000_0100);
    check("t4_inst", oinst, exp_inst(32'h8000_0100));
    check("t4_addr", last_addr, 32'h8000_0100);

    // misaligned redirect target
    rdy = 0;
    base = n_calls;
    rdv = 1; rdpc = 32'h8000_0102;
    tick(1);
    rdv = 0;
    check("t5_flush", ov, 0);
    tick(2);
`ifdef IFU_MISALIGN_CHECK_EN
    check("t5_fault", of, 1);
    check("t5_inst", oinst, 0);
    check("t5_pc", opc, 32'h8000_0102);
    check("t5_calls", n_calls - base, 0);
    tick(1);
    check("t5_busy", bsy, 0);
    check("t5_halt_calls", n_calls - base, 0);
`else
    check("t5_fault", of, 0);
    check("t5_pc", opc, 32'h8000_0102);
    check("t5_inst", oinst, 32'h8000_0100 ^ K);
    check("t5_calls", n_calls - base, 1);
    check("t5_addr", last_addr, 32'h8000_0102);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
